// File: rtl/bch_pkg.sv
// Shared BCH(63,51) t=2 constants and encoder state type, common to bch_encoder and bch_decoder.
package bch_pkg;
  localparam int          BCH_N         = 63;
  localparam int          BCH_K         = 51;
  localparam int          BCH_M         = 6;
  localparam int          BCH_NPAR      = 12;
  localparam logic [12:0] BCH_GEN_POLY  = 13'h1539;
  localparam logic [6:0]  BCH_PRIM_POLY = 7'h43;
  localparam logic [5:0]  BCH_POS_NONE  = 6'd63;

  typedef enum logic {ST_DATA, ST_PARITY} t_bch_enc_state;
endpackage

// File: rtl/bch_parity_lfsr.sv
// 12-bit g(x) divider: shift_in folds a message bit into the remainder, shift_out drains it MSB first.
// Updates take effect next cycle; clr has priority over both shift requests.
module bch_parity_lfsr
  import bch_pkg::*;
#(
  parameter logic [12:0] GEN_POLY = BCH_GEN_POLY
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic shift_in_en,
  input  logic din,
  input  logic shift_out_en,
  output logic parity_msb
);

  logic [11:0] lfsr_q, lfsr_d;
  logic        fb;

  always_comb begin
    lfsr_d = lfsr_q;
    fb     = din ^ lfsr_q[11];
    if (clr) begin
      lfsr_d = '0;
    end else if (shift_in_en) begin
      lfsr_d = {lfsr_q[10:0], 1'b0} ^ (fb ? GEN_POLY[11:0] : 12'h000);
    end else if (shift_out_en) begin
      lfsr_d = {lfsr_q[10:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= '0;
    else     lfsr_q <= lfsr_d;
  end

  assign parity_msb = lfsr_q[11];

endmodule

// File: rtl/bch_encoder.sv
// Systematic serial BCH(63,51) encoder: 1-cycle latency, 1 bit/clk, one-entry output stage stalls input when full.
// BCH_ENC_ERR_INJECT_EN adds inj_pos0/inj_pos1 to invert up to two transmitted bits per codeword.
module bch_encoder
  import bch_pkg::*;
#(
  parameter int          BCH_K    = bch_pkg::BCH_K,
  parameter int          BCH_NPAR = bch_pkg::BCH_NPAR,
  parameter logic [12:0] GEN_POLY = bch_pkg::BCH_GEN_POLY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic       out_data,
  output logic       out_last,
  input  logic       out_ready
`ifdef BCH_ENC_ERR_INJECT_EN
 ,input  logic [5:0] inj_pos0,
  input  logic [5:0] inj_pos1
`endif
);

  localparam logic [5:0] DATA_LAST = 6'(BCH_K - 1);
  localparam logic [5:0] PAR_LAST  = 6'(BCH_NPAR - 1);

  t_bch_enc_state state_q, state_d;
  logic [5:0]     bit_cnt_q, bit_cnt_d;
  logic           out_valid_q, out_valid_d;
  logic           out_data_q, out_data_d;
  logic           out_last_q, out_last_d;
  logic           stage_free, load_data, load_par, data_end, par_end;
  logic           lfsr_msb, flip;

  assign stage_free = !out_valid_q || out_ready;
  assign data_end   = load_data && (bit_cnt_q == DATA_LAST);
  assign par_end    = load_par && (bit_cnt_q == PAR_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_DATA;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DATA:   if (data_end) state_d = ST_PARITY;
      ST_PARITY: if (par_end)  state_d = ST_DATA;
      default:   state_d = ST_DATA;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    load_data = 1'b0;
    load_par  = 1'b0;
    case (state_q)
      ST_DATA: begin
        in_ready  = stage_free && !rst;
        load_data = in_valid && stage_free && !rst;
      end
      ST_PARITY: load_par = stage_free;
      default: ;
    endcase
  end

  // Parity drains from the LFSR MSB; the divider always sees the clean message bit.
  bch_parity_lfsr #(.GEN_POLY(GEN_POLY)) u_lfsr (
    .clk          (clk),
    .rst          (rst),
    .clr          (par_end),
    .shift_in_en  (load_data),
    .din          (in_data),
    .shift_out_en (load_par),
    .parity_msb   (lfsr_msb)
  );

`ifdef BCH_ENC_ERR_INJECT_EN
  logic [5:0] inj0_q, inj0_d, inj1_q, inj1_d, pos;
  logic       first_bit;

  // Positions are taken straight from the ports for c62 so it can be corrupted too.
  always_comb begin
    first_bit = load_data && (bit_cnt_q == 6'd0);
    inj0_d    = first_bit ? inj_pos0 : inj0_q;
    inj1_d    = first_bit ? inj_pos1 : inj1_q;
    pos       = load_data ? bit_cnt_q : bit_cnt_q + 6'(BCH_K);
    flip      = (pos == inj0_d) || (pos == inj1_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inj0_q <= BCH_POS_NONE;
      inj1_q <= BCH_POS_NONE;
    end else begin
      inj0_q <= inj0_d;
      inj1_q <= inj1_d;
    end
  end
`else
  assign flip = 1'b0;
`endif

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (data_end || par_end)       bit_cnt_d = '0;
    else if (load_data || load_par) bit_cnt_d = bit_cnt_q + 6'd1;
    if (load_data || load_par) begin
      out_valid_d = 1'b1;
      out_data_d  = (load_data ? in_data : lfsr_msb) ^ flip;
      out_last_d  = par_end;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_bch_encoder.sv
// Directed bench for bch_encoder: polynomial long-division reference model plus literal parity pins.
module tb_bch_encoder;

  logic clk = 1'b0;
  logic rst, in_valid, in_data, in_ready, out_valid, out_data, out_last, out_ready;

  always #5 clk = ~clk;

  bch_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
`ifdef BCH_ENC_ERR_INJECT_EN
   ,.inj_pos0  (6'd63),
    .inj_pos1  (6'd63)
`endif
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          xfer_cnt = 0;
  int          last_cnt = 0;
  int          last_cyc = 0;
  logic [62:0] cap = '0;
  bit          rand_ready = 1'b0;
  bit          exp_bit[$];
  bit          exp_last[$];
  bit          eb, el;
  int          l0, x0, t_first, nw;
  logic [50:0] m;

  // Remainder of v(x) divided by g(x), by schoolbook long division.
  function automatic logic [11:0] poly_mod(input logic [62:0] v);
    logic [62:0] r;
    r = v;
    for (int i = 62; i >= 12; i--)
      if (r[i]) r = r ^ (63'(13'h1539) << (i - 12));
    return r[11:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_bit.size() == 0) begin
        check("unexpected_bit", 64'd1, 64'd0);
      end else begin
        eb = exp_bit.pop_front();
        el = exp_last.pop_front();
        check("out_data", 64'(out_data), 64'(eb));
        check("out_last", 64'(out_last), 64'(el));
      end
      cap = {cap[61:0], out_data};
      xfer_cnt++;
      if (out_last) begin
        last_cnt++;
        last_cyc = cyc;
        check("codeword_mod_g", 64'(poly_mod(cap)), 64'd0);
      end
    end
  end

  task automatic send_bit(input logic b);
    int  n;
    logic acc;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 2000);
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_msg(input logic [50:0] msg, input bit gaps);
    logic [62:0] cw;
    cw = {msg, poly_mod({msg, 12'b0})};
    for (int i = 62; i >= 0; i--) begin
      exp_bit.push_back(cw[i]);
      exp_last.push_back(i == 0);
    end
    for (int i = 50; i >= 0; i--) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_bit(msg[i]);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_bit.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_timeout", 64'(exp_bit.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;

    check("model_c12_parity", 64'(poly_mod(63'd1 << 12)), 64'h539);
    check("model_zero_parity", 64'(poly_mod(63'd0)), 64'd0);
    check("model_gen_multiple", 64'(poly_mod(63'h1539 << 50)), 64'd0);

    // All-zero message: zero codeword, input blocked for the 12 parity cycles.
    l0 = last_cnt;
    send_msg(51'd0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("parity_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
    end
    @(negedge clk);
    check("next_cw_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    wait_drain();
    check("zero_cw", 64'(cap), 64'd0);
    check("zero_cw_last_cnt", 64'(last_cnt - l0), 64'd1);

    // Single 1 at c12: parity equals g(x) minus x^12.
    send_msg(51'd1, 1'b0);
    wait_drain();
    check("c12_parity", 64'(cap[11:0]), 64'h539);
    check("c12_msg", 64'(cap[62:12]), 64'd1);

    // Random messages with random gaps and random backpressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      m = 51'({$urandom(), $urandom()});
      send_msg(m, 1'b1);
    end
    wait_drain();
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset after 30 message bits: partial codeword is dropped.
    m = 51'({$urandom(), $urandom()});
    for (int i = 50; i >= 21; i--) begin
      exp_bit.push_back(m[i]);
      exp_last.push_back(1'b0);
    end
    for (int i = 50; i >= 21; i--) send_bit(m[i]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    exp_bit.delete();
    exp_last.delete();
    send_msg(51'd1, 1'b0);
    wait_drain();
    check("post_rst_cw", 64'(cap), 64'({51'd1, 12'h539}));

    // Back-to-back codewords with continuous in_valid.
    l0 = last_cnt;
    x0 = xfer_cnt;
    t_first = 0;
    fork
      begin
        send_msg(51'h5_5555_5555_5555, 1'b0);
        send_msg(51'h7_0F0F_0F0F_0F0F, 1'b0);
      end
      begin
        nw = 0;
        do begin
          @(negedge clk);
          nw++;
        end while (!out_valid && nw < 100);
        t_first = cyc;
        nw = 0;
        while (last_cnt < l0 + 2 && nw < 500) begin
          @(posedge clk);
          nw++;
        end
      end
    join
    wait_drain();
    check("b2b_last_cnt", 64'(last_cnt - l0), 64'd2);
    check("b2b_xfer_cnt", 64'(xfer_cnt - x0), 64'd126);
    check("b2b_span", 64'(last_cyc - t_first), 64'd125);

    check("final_queue_empty", 64'(exp_bit.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
